// File: rtl/bnn_pkg.sv
// Shared BNN definitions: popcount sizing, accumulator width helper and the
// packer output-state encoding.
package bnn_pkg;

  // Number of inputs reduced by the upstream XNOR-popcount stage.
  localparam int unsigned POPCOUNT_N    = 576;
  // Width needed to hold a popcount of 0..POPCOUNT_N.
  localparam int unsigned POP_W_DEFAULT = $clog2(POPCOUNT_N + 1);

  typedef logic [POP_W_DEFAULT-1:0] pop_t;

  // Output register state of the bit packer.
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } out_state_e;

  // Accumulator/threshold width: enough for parts * (2^pop_w - 1) plus margin.
  function automatic int unsigned acc_width(input int unsigned pop_w,
                                            input int unsigned parts);
    return pop_w + $clog2(parts) + 1;
  endfunction

endpackage

// File: rtl/pop_threshold_binarizer_if.sv
// Popcount-in / packed-activation-out stream bundle of the threshold binarizer.
interface pop_threshold_binarizer_if
  import bnn_pkg::*;
#(
  parameter int unsigned POP_W = POP_W_DEFAULT,
  parameter int unsigned ACC_W = acc_width(POP_W_DEFAULT, 4),
  parameter int unsigned OUT_W = 16
);
  localparam int unsigned LEN_W = $clog2(OUT_W + 1);

  logic             in_valid;
  logic             in_ready;
  logic [POP_W-1:0] in_pop;
  logic [ACC_W-1:0] thr;
  logic             thr_flip;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_bits;
  logic [LEN_W-1:0] out_len;

  // Environment side: drives popcounts and consumes packed words.
  modport master (
    output in_valid, in_pop, thr, thr_flip, flush, out_ready,
    input  in_ready, out_valid, out_bits, out_len
  );

  // Binarizer side.
  modport slave (
    input  in_valid, in_pop, thr, thr_flip, flush, out_ready,
    output in_ready, out_valid, out_bits, out_len
  );

endinterface

// File: rtl/pop_threshold_binarizer_bit_packer.sv
// Serial activation bits -> LSB-first packed words, with flush of a partial
// word and a one-deep registered output stage.
module pop_threshold_binarizer_bit_packer
  import bnn_pkg::*;
#(
  parameter  int unsigned OUT_W = 16,
  localparam int unsigned LEN_W = $clog2(OUT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_bits,
  output logic [LEN_W-1:0] out_len,
  output logic             word_fire_c
);

  localparam int unsigned BC_W = $clog2(OUT_W);

  out_state_e       state_q;
  out_state_e       state_d;
  logic [BC_W-1:0]  bit_cnt;
  logic [OUT_W-1:0] pack;
  logic [OUT_W-1:0] pack_nxt;
  logic [LEN_W-1:0] cnt_after;
  logic             complete;
  logic             flush_emit;
  logic             load;

  // Pack contents after this cycle's bit, and whether a word leaves now.
  always_comb begin
    pack_nxt = pack;
    if (bit_valid) begin
      pack_nxt[bit_cnt] = bit_in;
    end
    cnt_after  = LEN_W'(bit_cnt) + LEN_W'(bit_valid);
    complete   = bit_valid && (bit_cnt == BC_W'(OUT_W - 1));
    // A word completed by the same-cycle bit already leaves; no empty extra.
    flush_emit = flush && !complete && (cnt_after != '0);
    load       = complete || flush_emit;
  end

  // Output state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next output state; loads only happen while the output is free or draining.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: begin
        if (load) begin
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (out_ready && !load) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  assign out_valid   = (state_q == S_FULL);
  assign word_fire_c = out_valid && out_ready;

  // Pack register and fill count; cleared whenever a word or flush leaves.
  always_ff @(posedge clk) begin
    if (reset || load || flush) begin
      pack    <= '0;
      bit_cnt <= '0;
    end else if (bit_valid) begin
      pack    <= pack_nxt;
      bit_cnt <= bit_cnt + BC_W'(1);
    end
  end

  // Output word register; held until a new word is loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_bits <= '0;
      out_len  <= '0;
    end else if (load) begin
      out_bits <= pack_nxt;
      out_len  <= complete ? LEN_W'(OUT_W) : cnt_after;
    end
  end

endmodule

// File: rtl/pop_threshold_binarizer.sv
// Accumulates ACC_PARTS partial popcounts per neuron, thresholds the sum into
// one activation bit and packs the bits into OUT_W-bit words.
// Optional statistics counters: define POP_THRESHOLD_BINARIZER_STATS_EN.
module pop_threshold_binarizer
  import bnn_pkg::*;
#(
  parameter int unsigned POP_W     = POP_W_DEFAULT,
  parameter int unsigned ACC_PARTS = 4,
  parameter int unsigned OUT_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  pop_threshold_binarizer_if.slave bus
`ifdef POP_THRESHOLD_BINARIZER_STATS_EN
  ,
  output logic [31:0]             ones_cnt,
  output logic [31:0]             word_cnt
`endif
);

  localparam int unsigned ACC_W = acc_width(POP_W, ACC_PARTS);
  localparam int unsigned PC_W  = (ACC_PARTS > 1) ? $clog2(ACC_PARTS) : 1;

  logic [ACC_W-1:0] acc;
  logic [PC_W-1:0]  part_cnt;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] sum;
  logic             in_ready_c;
  logic             accept;
  logic             flush_act;
  logic             last_part;
  logic             decide;
  logic             dec_bit;
  logic             word_fire_c;

  assign in_ready_c = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = in_ready_c;

  // Handshake qualification, running sum and threshold decision.
  always_comb begin
    accept    = bus.in_valid && in_ready_c;
    flush_act = bus.flush && in_ready_c;
    last_part = (part_cnt == PC_W'(ACC_PARTS - 1));
    acc_base  = (part_cnt == '0) ? '0 : acc;
    sum       = acc_base + ACC_W'(bus.in_pop);
    decide    = accept && last_part;
    dec_bit   = bus.thr_flip ? (sum < bus.thr) : (sum >= bus.thr);
  end

  // Neuron accumulator; a flush drops any in-progress neuron.
  always_ff @(posedge clk) begin
    if (reset || flush_act) begin
      acc      <= '0;
      part_cnt <= '0;
    end else if (accept) begin
      acc      <= sum;
      part_cnt <= last_part ? '0 : part_cnt + PC_W'(1);
    end
  end

  pop_threshold_binarizer_bit_packer #(
    .OUT_W (OUT_W)
  ) u_packer (
    .clk         (clk),
    .reset       (reset),
    .bit_valid   (decide),
    .bit_in      (dec_bit),
    .flush       (flush_act),
    .out_ready   (bus.out_ready),
    .out_valid   (bus.out_valid),
    .out_bits    (bus.out_bits),
    .out_len     (bus.out_len),
    .word_fire_c (word_fire_c)
  );

`ifdef POP_THRESHOLD_BINARIZER_STATS_EN
  // Running count of 1-decisions and emitted words, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      ones_cnt <= '0;
      word_cnt <= '0;
    end else begin
      if (decide && dec_bit) begin
        ones_cnt <= ones_cnt + 32'd1;
      end
      if (word_fire_c) begin
        word_cnt <= word_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_word_fire;
  assign unused_word_fire = word_fire_c;
`endif

endmodule

// File: tb/tb_pop_threshold_binarizer.sv
// Directed bench for pop_threshold_binarizer with a word scoreboard.
module tb_pop_threshold_binarizer;
  import bnn_pkg::*;

  localparam int unsigned P_POP_W     = POP_W_DEFAULT;
  localparam int unsigned P_ACC_PARTS = 4;
  localparam int unsigned P_OUT_W     = 16;
  localparam int unsigned P_ACC_W     = acc_width(P_POP_W, P_ACC_PARTS);
  localparam int unsigned P_LEN_W     = $clog2(P_OUT_W + 1);

  typedef struct packed {
    logic [P_OUT_W-1:0] bits;
    logic [P_LEN_W-1:0] len;
  } word_t;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pop_threshold_binarizer_if #(.POP_W(P_POP_W), .ACC_W(P_ACC_W), .OUT_W(P_OUT_W)) bus ();

`ifdef POP_THRESHOLD_BINARIZER_STATS_EN
  logic [31:0] ones_cnt;
  logic [31:0] word_cnt;
`endif

  pop_threshold_binarizer #(
    .POP_W     (P_POP_W),
    .ACC_PARTS (P_ACC_PARTS),
    .OUT_W     (P_OUT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave)
`ifdef POP_THRESHOLD_BINARIZER_STATS_EN
    ,
    .ones_cnt (ones_cnt),
    .word_cnt (word_cnt)
`endif
  );

  word_t              exp_q[$];
  int                 n_cmp;
  int                 n_fail;
  int                 mpart;
  int                 msum;
  int                 mcnt;
  int                 mones;
  int                 mwords;
  int                 obs_words;
  int                 stalls;
  logic [P_OUT_W-1:0] mpack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input int len);
    word_t w;
    w.bits = mpack;
    w.len  = P_LEN_W'(len);
    exp_q.push_back(w);
    mwords++;
    mpack = '0;
    mcnt  = 0;
  endtask

  task automatic model_bit(input bit b);
    mpack[mcnt] = b;
    mcnt++;
    if (b) mones++;
    if (mcnt == int'(P_OUT_W)) push_word(mcnt);
  endtask

  task automatic model_pop(input int pop, input int thr, input bit flip);
    if (mpart == 0) msum = pop;
    else msum = msum + pop;
    if (mpart == int'(P_ACC_PARTS) - 1) begin
      mpart = 0;
      model_bit(flip ? (msum < thr) : (msum >= thr));
    end else begin
      mpart++;
    end
  endtask

  task automatic model_flush();
    if (mcnt > 0) push_word(mcnt);
    mpart = 0;
    msum  = 0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    mpack  = '0;
    mcnt   = 0;
    mpart  = 0;
    msum   = 0;
    mones  = 0;
    mwords = 0;
  endtask

  // One clock: sample at the falling edge, update model/scoreboard, step.
  task automatic cyc(output bit acc);
    bit    fl;
    word_t w;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready && !reset;
    fl  = bus.flush && bus.in_ready && !reset;
    if (bus.in_valid && !bus.in_ready) stalls++;
    if (bus.out_valid && bus.out_ready && !reset) begin
      obs_words++;
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_word: observed bits 0x%0h len %0d, expected no word",
               bus.out_bits, bus.out_len);
      end
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("word_bits", 32'(bus.out_bits), 32'(w.bits));
        check("word_len", 32'(bus.out_len), 32'(w.len));
      end
    end
    if (acc) model_pop(int'(bus.in_pop), int'(bus.thr), bus.thr_flip);
    if (fl) model_flush();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) cyc(acc);
  endtask

  task automatic send_pop(input int pop, input int thr, input bit flip, input bit fl);
    bit acc;
    acc          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pop   = P_POP_W'(pop);
    bus.thr      = P_ACC_W'(thr);
    bus.thr_flip = flip;
    bus.flush    = fl;
    for (int i = 0; i < 200 && !acc; i++) cyc(acc);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("send_accepted", 32'(acc), 32'd1);
  endtask

  // Sum lands exactly on or one below thr=400 so the bit equals b.
  task automatic send_neuron(input bit b, input bit flip, input bit fl_last);
    for (int i = 0; i < 3; i++) send_pop(100, 400, flip, 1'b0);
    send_pop((b ^ flip) ? 100 : 99, 400, flip, fl_last);
  endtask

  task automatic send_random_neuron();
    int thr;
    bit flip;
    thr  = int'($urandom_range(0, 4 * 1023 + 1));
    flip = 1'($urandom_range(0, 1));
    for (int i = 0; i < int'(P_ACC_PARTS); i++)
      send_pop(int'($urandom_range(0, 1023)), thr, flip, 1'b0);
  endtask

  task automatic do_flush();
    bit acc;
    bus.flush = 1'b1;
    cyc(acc);
    bus.flush = 1'b0;
  endtask

  initial begin
    int w0;
    int s0;
    bit acc;
    n_cmp        = 0;
    n_fail       = 0;
    obs_words    = 0;
    stalls       = 0;
    model_reset();
    bus.in_valid  = 1'b0;
    bus.in_pop    = '0;
    bus.thr       = '0;
    bus.thr_flip  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_bits", 32'(bus.out_bits), 32'd0);
    check("rst_out_len", 32'(bus.out_len), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // 1: threshold boundary, both polarities, then flush out the 4 bits
    send_neuron(1'b1, 1'b0, 1'b0);
    send_neuron(1'b0, 1'b0, 1'b0);
    send_neuron(1'b0, 1'b1, 1'b0);
    send_neuron(1'b1, 1'b1, 1'b0);
    do_flush();
    idle(3);

    // 2: alternating decisions -> 0x5555, valid for exactly one cycle
    for (int i = 0; i < 16; i++) send_neuron(bit'(i % 2 == 0), 1'b0, 1'b0);
    check("t2_valid_first", 32'(bus.out_valid), 32'd1);
    cyc(acc);
    check("t2_valid_after", 32'(bus.out_valid), 32'd0);

    // 3: 35 neurons at full rate, no input stalls, then a 3-bit flush word
    s0 = stalls;
    w0 = obs_words;
    for (int i = 0; i < 35; i++) send_random_neuron();
    check("t3_no_bubble", 32'(stalls - s0), 32'd0);
    do_flush();
    idle(3);
    check("t3_words", 32'(obs_words - w0), 32'd3);

    // 4: consumer stalls after a word; input held off, word stable
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_random_neuron();
    bus.in_valid = 1'b1;
    bus.in_pop   = P_POP_W'(100);
    bus.thr      = P_ACC_W'(400);
    bus.thr_flip = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(acc);
      check("t4_no_accept", 32'(acc), 32'd0);
      check("t4_in_ready", 32'(bus.in_ready), 32'd0);
      check("t4_out_valid", 32'(bus.out_valid), 32'd1);
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL t4_pending: observed empty scoreboard, expected one held word");
      end
      if (exp_q.size() != 0) check("t4_bits_stable", 32'(bus.out_bits), 32'(exp_q[0].bits));
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_neuron(bit'(i % 2 == 1), 1'b0, 1'b0);
    idle(3);

    // 5: reset mid-word and mid-neuron discards everything
    for (int i = 0; i < 7; i++) send_random_neuron();
    send_pop(500, 400, 1'b0, 1'b0);
    send_pop(500, 400, 1'b0, 1'b0);
    w0 = obs_words;
    reset = 1'b1;
    idle(2);
    model_reset();
    reset = 1'b0;
    check("t5_out_valid", 32'(bus.out_valid), 32'd0);
    check("t5_out_len", 32'(bus.out_len), 32'd0);
    idle(2);
    check("t5_no_word", 32'(obs_words - w0), 32'd0);
    for (int i = 0; i < 16; i++) send_random_neuron();
    idle(3);
    check("t5_one_word", 32'(obs_words - w0), 32'd1);

    // 6: flush together with the word-completing partial -> single word
    w0 = obs_words;
`ifdef POP_THRESHOLD_BINARIZER_STATS_EN
    s0 = int'(word_cnt);
`endif
    for (int i = 0; i < 15; i++) send_random_neuron();
    send_neuron(1'b1, 1'b0, 1'b1);
    idle(4);
    check("t6_words", 32'(obs_words - w0), 32'd1);
`ifdef POP_THRESHOLD_BINARIZER_STATS_EN
    check("t6_word_cnt_delta", word_cnt - 32'(s0), 32'd1);
    check("stats_word_cnt", word_cnt, 32'(mwords));
    check("stats_ones_cnt", ones_cnt, 32'(mones));
`endif
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
